// File: rtl/ahb_resp_mux.sv
// ahb_resp_mux: AHB-Lite data-phase response mux with built-in default slave for unmapped regions
module ahb_resp_mux #(
  parameter int NSLV = 10,
  parameter int DW = 32
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic [3:0]       MUX_SEL,
  input  logic             HSEL_NOMAP,
  input  logic [1:0]       HTRANS,
  input  logic [NSLV*DW-1:0] HRDATA_S,
  input  logic [NSLV-1:0]  HREADYOUT_S,
  input  logic [NSLV-1:0]  HRESP_S,
  output logic [DW-1:0]    HRDATA,
  output logic             HREADY,
  output logic             HRESP
);
  typedef enum logic [1:0] {IDLE, ERR1, ERR2} state_t;
  state_t state, nxt;
  logic [3:0] sel_q;
  logic dflt_rdy, dflt_rsp, start;
  assign start = HREADY & HSEL_NOMAP & HTRANS[1];
  // capture the decoder's slave code at the end of each completed address phase
  always_ff @(posedge HCLK or posedge HRESET)
    if (HRESET) sel_q <= 4'hF;
    else if (HREADY) sel_q <= MUX_SEL;
  // default slave state register
  always_ff @(posedge HCLK or posedge HRESET)
    if (HRESET) state <= IDLE;
    else state <= nxt;
  // an accepted active transfer to an unmapped region runs the two-cycle ERROR sequence
  always_comb nxt = (state == ERR1) ? ERR2 : start ? ERR1 : IDLE;
  // default slave response: stall only in the first ERROR cycle, ERROR in both
  always_comb begin
    dflt_rdy = state != ERR1;
    dflt_rsp = state != IDLE;
  end
  // route the selected slave; unmapped and undefined codes fall through to the default slave
  always_comb begin
    HRDATA = '0;
    HREADY = dflt_rdy;
    HRESP = dflt_rsp;
    for (int i = 0; i < NSLV; i++)
      if (sel_q == 4'(i)) begin
        HRDATA = HRDATA_S[i*DW +: DW];
        HREADY = HREADYOUT_S[i];
        HRESP = HRESP_S[i];
      end
  end
endmodule

// File: tb/tb_ahb_resp_mux.sv
// tb_ahb_resp_mux: randomized and directed checks of ahb_resp_mux against a behavioural model
module tb_ahb_resp_mux;
  localparam int NSLV = 10;
  localparam int DW = 32;
  localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10;
  logic HCLK = 0, HRESET = 0;
  logic [3:0] MUX_SEL = 4'hF;
  logic HSEL_NOMAP = 1'b0;
  logic [1:0] HTRANS = T_IDLE;
  logic [NSLV*DW-1:0] HRDATA_S = '0;
  logic [NSLV-1:0] HREADYOUT_S = '1, HRESP_S = '0;
  logic [DW-1:0] HRDATA;
  logic HREADY, HRESP;
  int n_chk = 0, n_fail = 0;
  bit cmp_on = 0;
  int msel = 15;
  int err_left = 0;

  ahb_resp_mux #(.NSLV(NSLV), .DW(DW)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .MUX_SEL(MUX_SEL), .HSEL_NOMAP(HSEL_NOMAP),
    .HTRANS(HTRANS), .HRDATA_S(HRDATA_S), .HREADYOUT_S(HREADYOUT_S), .HRESP_S(HRESP_S),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  // expected response: selected slave passes through, otherwise the pending error cycles decide
  function automatic void model(output logic [DW-1:0] d, output logic r, output logic e);
    if (msel < NSLV) begin
      d = HRDATA_S[msel*DW +: DW];
      r = HREADYOUT_S[msel];
      e = HRESP_S[msel];
    end else begin
      d = '0;
      r = err_left != 2;
      e = err_left != 0;
    end
  endfunction

  // model state: data-phase select and number of error cycles still to present
  always @(posedge HCLK or posedge HRESET) begin
    logic [DW-1:0] d;
    logic r, e;
    if (HRESET) begin
      msel <= 15;
      err_left <= 0;
    end else begin
      model(d, r, e);
      err_left <= (r && HSEL_NOMAP && HTRANS[1]) ? 2 : (err_left > 0 ? err_left - 1 : 0);
      if (r) msel <= int'(MUX_SEL);
    end
  end

  // every-cycle comparison against the model, after inputs settle
  always @(negedge HCLK) begin
    logic [DW-1:0] d;
    logic r, e;
    #1;
    if (cmp_on) begin
      model(d, r, e);
      n_chk++;
      if (HRDATA !== d || HREADY !== r || HRESP !== e) begin
        n_fail++;
        $display("FAIL model t=%0t: got %h/%b/%b want %h/%b/%b", $time, HRDATA, HREADY, HRESP, d, r, e);
      end
    end
  end

  task automatic chk(input string name, input logic [DW-1:0] d, input logic r, input logic e);
    n_chk++;
    if (HRDATA !== d || HREADY !== r || HRESP !== e) begin
      n_fail++;
      $display("FAIL %s: got %h/%b/%b want %h/%b/%b", name, HRDATA, HREADY, HRESP, d, r, e);
    end
  endtask

  task automatic drive(input logic [3:0] s, input logic [1:0] t);
    @(negedge HCLK);
    MUX_SEL = s;
    HSEL_NOMAP = s >= NSLV;
    HTRANS = t;
    #2;
  endtask

  task automatic reset_pulse(input string name);
    #1 HRESET = 1;
    #1 chk(name, '0, 1'b1, 1'b0);
    #4 HRESET = 0;
  endtask

  initial begin
    #1 HRESET = 1;
    #12 chk("reset", '0, 1'b1, 1'b0);
    HRESET = 0;
    cmp_on = 1;
    HRDATA_S[2*DW +: DW] = 32'hDEADBEEF;
    drive(4'd2, T_NSEQ);
    drive(4'hF, T_IDLE);
    chk("t2_read", 32'hDEADBEEF, 1'b1, 1'b0);
    reset_pulse("t1_rst_mapped");
    drive(4'hF, T_IDLE);
    chk("t1_after_rst", '0, 1'b1, 1'b0);
    HRDATA_S[3*DW +: DW] = 32'h3333_0003;
    HRDATA_S[5*DW +: DW] = 32'h5555_0005;
    drive(4'd3, T_NSEQ);
    HREADYOUT_S[3] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(4'd5, T_NSEQ);
      chk("t3_stall", 32'h3333_0003, 1'b0, 1'b0);
    end
    @(negedge HCLK);
    HREADYOUT_S[3] = 1'b1;
    #2 chk("t3_done", 32'h3333_0003, 1'b1, 1'b0);
    drive(4'hF, T_IDLE);
    chk("t3_slave5", 32'h5555_0005, 1'b1, 1'b0);
    drive(4'hF, T_NSEQ);
    chk("t4_addr", '0, 1'b1, 1'b0);
    drive(4'hF, T_IDLE);
    chk("t4_err1", '0, 1'b0, 1'b1);
    drive(4'hF, T_IDLE);
    chk("t4_err2", '0, 1'b1, 1'b1);
    drive(4'hF, T_IDLE);
    chk("t4_idle", '0, 1'b1, 1'b0);
    drive(4'hF, T_NSEQ);
    chk("t5_addr", '0, 1'b1, 1'b0);
    drive(4'hF, T_NSEQ);
    chk("t5_err1a", '0, 1'b0, 1'b1);
    drive(4'hF, T_NSEQ);
    chk("t5_err2a", '0, 1'b1, 1'b1);
    drive(4'hF, T_IDLE);
    chk("t5_err1b", '0, 1'b0, 1'b1);
    drive(4'hF, T_IDLE);
    chk("t5_err2b", '0, 1'b1, 1'b1);
    drive(4'hF, T_BUSY);
    chk("t5_idle", '0, 1'b1, 1'b0);
    drive(4'hF, T_IDLE);
    chk("t5_busy_okay", '0, 1'b1, 1'b0);
    HRDATA_S[0 +: DW] = 32'h0000_C0DE;
    drive(4'hF, T_NSEQ);
    chk("t6_addr", '0, 1'b1, 1'b0);
    drive(4'hF, T_IDLE);
    chk("t6_err1", '0, 1'b0, 1'b1);
    reset_pulse("t6_rst_err1");
    drive(4'd0, T_NSEQ);
    chk("t6_idle", '0, 1'b1, 1'b0);
    drive(4'hF, T_IDLE);
    chk("t6_slave0", 32'h0000_C0DE, 1'b1, 1'b0);
    for (int n = 0; n < 3000; n++) begin
      @(negedge HCLK);
      for (int i = 0; i < NSLV; i++) begin
        HRDATA_S[i*DW +: DW] = $urandom;
        HREADYOUT_S[i] = $urandom_range(0, 3) != 0;
        HRESP_S[i] = $urandom_range(0, 7) == 0;
      end
      MUX_SEL = 4'($urandom_range(0, 15));
      HSEL_NOMAP = MUX_SEL >= NSLV;
      HTRANS = 2'($urandom_range(0, 3));
      #2;
      if ($urandom_range(0, 99) == 0) reset_pulse("rnd_rst");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
